// File: rtl/sng_pkg.sv
// -----------------------------------------------------------------------------
// sng_pkg
//   Types and helpers shared by the SNG scheduler and by every site that
//   instantiates a stochastic number generator.
//   - sch_state_e : scheduler FSM states
//   - sl(bw)      : stochastic stream length for a bw-bit operand (2**bw)
// -----------------------------------------------------------------------------
package sng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        STOP,
        DONE
    } sch_state_e;

    function automatic int sl(input int bw);
        return 1 << bw;
    endfunction

endpackage

// File: rtl/sng_sched_if.sv
// -----------------------------------------------------------------------------
// sng_sched_if
//   Bundles the requester side and the SNG side of the scheduler.
//   Requester side : i_req, i_x, o_gnt, o_stream, o_id, o_done, o_busy
//   SNG side       : o_sng_x, o_sng_start, o_sng_stop, i_sng_bit
//   Optional       : o_cnt_err (present only when SNG_CHECK_EN is defined)
//   Modports       : slave  - the scheduler itself
//                    master - whatever drives requests and models the SNG
// -----------------------------------------------------------------------------
interface sng_sched_if #(
    parameter int N_REQ = 4,
    parameter int BW    = 4
);
    import sng_pkg::*;

    localparam int SL = sl(BW);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    i_req;
    logic [N_REQ*BW-1:0] i_x;
    logic [N_REQ-1:0]    o_gnt;
    logic [BW-1:0]       o_sng_x;
    logic                o_sng_start;
    logic                o_sng_stop;
    logic                i_sng_bit;
    logic [SL-1:0]       o_stream;
    logic [IW-1:0]       o_id;
    logic                o_done;
    logic                o_busy;
`ifdef SNG_CHECK_EN
    logic                o_cnt_err;

    modport slave (
        input  i_req, i_x, i_sng_bit,
        output o_gnt, o_sng_x, o_sng_start, o_sng_stop,
               o_stream, o_id, o_done, o_busy, o_cnt_err
    );

    modport master (
        output i_req, i_x, i_sng_bit,
        input  o_gnt, o_sng_x, o_sng_start, o_sng_stop,
               o_stream, o_id, o_done, o_busy, o_cnt_err
    );
`else
    modport slave (
        input  i_req, i_x, i_sng_bit,
        output o_gnt, o_sng_x, o_sng_start, o_sng_stop,
               o_stream, o_id, o_done, o_busy
    );

    modport master (
        output i_req, i_x, i_sng_bit,
        input  o_gnt, o_sng_x, o_sng_start, o_sng_stop,
               o_stream, o_id, o_done, o_busy
    );
`endif

endinterface

// File: rtl/sng_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first asserted request at or
//   after ptr_i (wrapping modulo N_REQ) wins. The pointer register lives in
//   the caller.
//   req_i  : request vector
//   ptr_i  : highest-priority index
//   en_i   : when low, no grant is produced
//   gnt_o  : one-hot grant (all zero if nothing requested / disabled)
//   idx_o  : encoded index of gnt_o (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down to the pointer so the nearest
    // requester is the last one written and therefore wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        if (en_i) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (req_i[wrap_idx(ptr_i, i)]) begin
                    gnt_o                    = '0;
                    gnt_o[wrap_idx(ptr_i, i)] = 1'b1;
                    idx_o                    = wrap_idx(ptr_i, i);
                end
            end
        end
    end

endmodule

// File: rtl/sng_sched.sv
// -----------------------------------------------------------------------------
// sng_sched
//   Round-robin scheduler sharing one SNG between N_REQ requesters. A granted
//   operand is handed to the SNG, the SNG is started, SL = 2**BW serial bits
//   are captured, the SNG is stopped and the stream is returned with the
//   requester id.
//   i_clk_sch   : clock, rising edge
//   i_rst_n_sch : asynchronous active-low reset
//   bus         : sng_sched_if.slave (requests/operands, grant, SNG control,
//                 captured stream, id, done, busy)
//   Optional feature macro SNG_CHECK_EN: adds bus.o_cnt_err, set with o_done
//   when the number of ones captured differs from the operand.
// -----------------------------------------------------------------------------
module sng_sched
    import sng_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int BW    = 4
) (
    input  logic        i_clk_sch,
    input  logic        i_rst_n_sch,
    sng_sched_if.slave  bus
);

    localparam int SL = sl(BW);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [BW-1:0] J_LAST = '1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    sch_state_e     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  gidx_q, gidx_d;
    logic [BW-1:0]  x_q, x_d;
    logic [BW-1:0]  j_q, j_d;
    logic [SL-1:0]  cap_q, cap_d;
    logic [SL-1:0]  stream_q, stream_d;
    logic [IW-1:0]  id_q, id_d;
`ifdef SNG_CHECK_EN
    logic [BW:0]    cnt_q, cnt_d;
    logic           err_q, err_d;
`endif

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic [N_REQ-1:0] gnt;
    logic             start, stop, done;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req_i (bus.i_req),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        x_d      = x_q;
        j_d      = j_q;
        cap_d    = cap_q;
        stream_d = stream_q;
        id_d     = id_q;
`ifdef SNG_CHECK_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        gnt      = '0;
        start    = 1'b0;
        stop     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Operand is latched here so it is already stable on
                // o_sng_x while the start pulse is high.
                if (|arb_gnt) begin
                    gidx_d  = arb_idx;
                    x_d     = bus.i_x[arb_idx*BW +: BW];
                    state_d = START;
                end
            end
            START: begin
                gnt[gidx_q] = 1'b1;
                start       = 1'b1;
                ptr_d       = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
                j_d         = '0;
`ifdef SNG_CHECK_EN
                cnt_d       = '0;
`endif
                state_d     = STREAM;
            end
            STREAM: begin
                // SL-1-j equals the bitwise inverse of j for a BW-bit j.
                cap_d[~j_q] = bus.i_sng_bit;
                j_d         = j_q + 1'b1;
`ifdef SNG_CHECK_EN
                cnt_d       = cnt_q + (BW+1)'(bus.i_sng_bit);
`endif
                if (j_q == J_LAST) state_d = STOP;
            end
            STOP: begin
                stop     = 1'b1;
                stream_d = cap_q;
                id_d     = gidx_q;
`ifdef SNG_CHECK_EN
                err_d    = (cnt_q != {1'b0, x_q});
`endif
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sch or negedge i_rst_n_sch) begin
        if (!i_rst_n_sch) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            x_q      <= '0;
            j_q      <= '0;
            cap_q    <= '0;
            stream_q <= '0;
            id_q     <= '0;
`ifdef SNG_CHECK_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            x_q      <= x_d;
            j_q      <= j_d;
            cap_q    <= cap_d;
            stream_q <= stream_d;
            id_q     <= id_d;
`ifdef SNG_CHECK_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_sng_x     = x_q;
    assign bus.o_sng_start = start;
    assign bus.o_sng_stop  = stop;
    assign bus.o_stream    = stream_q;
    assign bus.o_id        = id_q;
    assign bus.o_done      = done;
    assign bus.o_busy      = (state_q != IDLE);
`ifdef SNG_CHECK_EN
    assign bus.o_cnt_err   = err_q;
`endif

endmodule
